// File: rtl/conv_sched.sv
// conv_sched: sequencer for the 3x3 convolution datapath.
// Loads the nine kernel weights once, then walks every valid 3x3 window of
// the pixel map in row-major order. Each window is fetched, fired into the
// datapath, and its result is handed out under a valid/ready handshake.
// After the last window the dense phase runs, followed by a done pulse.
module conv_sched #(
  parameter int SIZE      = 23,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int ADDR_W    = 6,
  parameter int CONV_LAT  = 2,
  parameter int DENSE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                pix_rd,
  output logic [ADDR_W-1:0]   pix_addr,
  input  logic [SIZE-1:0]     pix_data,
  output logic                wt_rd,
  output logic [3:0]          wt_addr,
  input  logic [SIZE-1:0]     wt_data,
  output logic [9*SIZE-1:0]   win_flat,
  output logic [9*SIZE-1:0]   kern_flat,
  output logic                conv_en,
  output logic                dense_en,
  input  logic [2*SIZE-2:0]   conv_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [2*SIZE-2:0]   out_data,
  output logic                busy,
  output logic                done
);

  localparam int OUT_W = 2*SIZE-1;
  // The phase counter must reach 9 (read phases) and the WAIT/DENSE lengths.
  localparam int CNT_W = $clog2(10 + CONV_LAT + DENSE_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_RD_END     = CNT_W'(9);
  localparam logic [CNT_W-1:0] CNT_WAIT_LAST  = CNT_W'(CONV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_DENSE_LAST = CNT_W'(DENSE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_K = 3'd1,
    S_FETCH  = 3'd2,
    S_FIRE   = 3'd3,
    S_WAIT   = 3'd4,
    S_WRITE  = 3'd5,
    S_DENSE  = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   r_q, r_d;
  logic [ADDR_W-1:0]   c_q, c_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;

  logic [SIZE-1:0]     kern_q [9];
  logic [SIZE-1:0]     win_q  [9];
  logic                kern_we, win_we;
  logic [3:0]          slot_idx;

  logic                rd_phase;
  logic [1:0]          j_row, j_col;
  logic [ADDR_W-1:0]   pix_addr_c;

  // Read phases are counter values 0..8; the capture for slot k lands one
  // cycle later, when the counter reads k+1.
  assign rd_phase = (cnt_q < CNT_RD_END);
  assign slot_idx = 4'(cnt_q - CNT_W'(1));

  // Split the fetch index into its row/column offset inside the window.
  always_comb begin
    j_row = 2'd0;
    j_col = 2'(cnt_q);
    if (cnt_q >= CNT_W'(6)) begin
      j_row = 2'd2;
      j_col = 2'(cnt_q - CNT_W'(6));
    end else if (cnt_q >= CNT_W'(3)) begin
      j_row = 2'd1;
      j_col = 2'(cnt_q - CNT_W'(3));
    end
  end

  assign pix_addr_c = ADDR_W'((int'(r_q) + int'(j_row)) * IMG_W
                              + int'(c_q) + int'(j_col));

  // Next-state logic: phase sequencing, window stepping and result capture.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold its value.
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    kern_we     = 1'b0;
    win_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        r_d   = '0;
        c_d   = '0;
        cnt_d = '0;
        if (start) state_d = S_LOAD_K;
      end

      S_LOAD_K: begin
        kern_we = (cnt_q != '0);
        if (cnt_q == CNT_RD_END) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FETCH: begin
        win_we = (cnt_q != '0);
        if (cnt_q == CNT_RD_END) begin
          cnt_d   = '0;
          state_d = S_FIRE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FIRE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (cnt_q == CNT_WAIT_LAST) begin
          out_valid_d = 1'b1;
          out_data_d  = conv_y;
          out_addr_d  = ADDR_W'(int'(r_q) * (IMG_W - 2) + int'(c_q));
          cnt_d       = '0;
          state_d     = S_WRITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WRITE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (int'(c_q) < IMG_W - 3) begin
            c_d     = c_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else if (int'(r_q) < IMG_H - 3) begin
            c_d     = '0;
            r_d     = r_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_DENSE;
          end
        end
      end

      S_DENSE: begin
        if (cnt_q == CNT_DENSE_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition; it also covers start+abort in IDLE.
    if (abort) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      kern_we     = 1'b0;
      win_we      = 1'b0;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  // Kernel and window slot registers, written one slot per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these slot arrays are cleared on reset because they drive the
    // datapath ports directly and must read as zero after reset; a plain
    // storage RAM would normally be left unreset.
    if (!rst_n) begin
      for (int j = 0; j < 9; j++) begin
        kern_q[j] <= '0;
        win_q[j]  <= '0;
      end
    end else begin
      if (kern_we) kern_q[slot_idx] <= wt_data;
      if (win_we)  win_q[slot_idx]  <= pix_data;
    end
  end

  for (genvar g = 0; g < 9; g++) begin : g_flat
    assign win_flat[g*SIZE +: SIZE]  = win_q[g];
    assign kern_flat[g*SIZE +: SIZE] = kern_q[g];
  end

  assign wt_rd     = (state_q == S_LOAD_K) && rd_phase;
  assign wt_addr   = wt_rd ? 4'(cnt_q) : 4'd0;
  assign pix_rd    = (state_q == S_FETCH) && rd_phase;
  assign pix_addr  = pix_rd ? pix_addr_c : '0;
  assign conv_en   = (state_q == S_FIRE);
  assign dense_en  = (state_q == S_DENSE);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_sched.sv
// Testbench for conv_sched: memory and datapath stubs, a window-level
// reference model feeding a scoreboard, and a monitor that checks results.
module tb_conv_sched;

  localparam int SIZE      = 23;
  localparam int IMG_W     = 8;
  localparam int IMG_H     = 8;
  localparam int ADDR_W    = 6;
  localparam int CONV_LAT  = 2;
  localparam int DENSE_CYC = 4;
  localparam int OUT_W     = 2*SIZE-1;
  localparam int N_OUT     = (IMG_W-2)*(IMG_H-2);
  localparam int NPIX      = IMG_W*IMG_H;
  localparam logic [OUT_W-1:0] POISON = OUT_W'(64'h0ABC_DEF1_2345);

  logic                clk = 1'b0;
  logic                rst_n, start, abort;
  logic                pix_rd, wt_rd, conv_en, dense_en;
  logic [ADDR_W-1:0]   pix_addr, out_addr;
  logic [SIZE-1:0]     pix_data = '0, wt_data = '0;
  logic [3:0]          wt_addr;
  logic [9*SIZE-1:0]   win_flat, kern_flat;
  logic [OUT_W-1:0]    conv_y, out_data;
  logic                out_valid, out_ready, busy, done;

  conv_sched #(
    .SIZE(SIZE), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
    .CONV_LAT(CONV_LAT), .DENSE_CYC(DENSE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data),
    .wt_rd(wt_rd), .wt_addr(wt_addr), .wt_data(wt_data),
    .win_flat(win_flat), .kern_flat(kern_flat),
    .conv_en(conv_en), .dense_en(dense_en), .conv_y(conv_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous memories: data appears the cycle after the read strobe and is
  // junk otherwise, so mistimed captures show up.
  logic [SIZE-1:0] pix_mem [NPIX];
  logic [SIZE-1:0] wt_mem  [9];

  always @(posedge clk) begin
    pix_data <= pix_rd ? pix_mem[pix_addr] : SIZE'($urandom);
    wt_data  <= wt_rd  ? wt_mem[wt_addr]   : SIZE'($urandom);
  end

  // Datapath stub: a mixing function of all window and kernel slots, or
  // pass-through of the centre pixel. The result is only valid exactly
  // CONV_LAT cycles after conv_en.
  bit pass_mode = 1'b1;
  logic [CONV_LAT-1:0] fire_sh;

  function automatic logic [OUT_W-1:0] dp_fn(input logic [9*SIZE-1:0] w,
                                             input logic [9*SIZE-1:0] k,
                                             input bit pass);
    logic [63:0] acc;
    acc = 64'd0;
    if (pass) return OUT_W'(w[4*SIZE +: SIZE]);
    for (int j = 0; j < 9; j++)
      acc += 64'(w[j*SIZE +: SIZE]) * 64'(2*j + 1) + 64'(k[j*SIZE +: SIZE]) * 64'(3*j + 20);
    return OUT_W'(acc);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fire_sh <= '0;
    else        fire_sh <= {fire_sh[CONV_LAT-2:0], conv_en};
  end

  assign conv_y = fire_sh[CONV_LAT-1] ? dp_fn(win_flat, kern_flat, pass_mode) : POISON;

  // Scoreboard of expected outputs, filled when a job is launched.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [OUT_W-1:0]  data;
  } exp_t;
  exp_t exp_q[$];

  // Consumer ready control.
  bit rand_ready  = 1'b0;
  bit ready_level = 1'b1;
  bit bp_arm      = 1'b0;
  int bp_hold     = 0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_hold > 1) begin
        out_ready = 1'b0;
        bp_hold--;
      end else if (bp_hold == 1) begin
        out_ready = 1'b1;
        bp_hold   = 0;
      end else if (bp_arm && out_valid && out_addr == ADDR_W'(3)) begin
        bp_arm    = 1'b0;
        out_ready = 1'b0;
        bp_hold   = 5;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_level;
      end
    end
  end

  // Output monitor: pops and compares on every accepted result, checks that
  // a stalled result stays put and that no fetch starts while it is pending.
  int   n_job_out = 0;
  int   done_cnt  = 0;
  int   dense_run = 0;
  int   stall     = 0;
  bit   bp_check  = 1'b0;
  bit   held      = 1'b0;
  logic [ADDR_W-1:0] held_addr;
  logic [OUT_W-1:0]  held_data;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("no_fetch_while_valid", pix_rd, 0);
      if (held) begin
        check("hold_addr", out_addr, held_addr);
        check("hold_data", out_data, held_data);
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_addr", out_addr, mon_e.addr);
          check("out_data", out_data, mon_e.data);
          if (bp_check && mon_e.addr == ADDR_W'(3))
            check("bp_stall_cycles", stall, 5);
        end
        n_job_out++;
        held  = 1'b0;
        stall = 0;
      end else begin
        held      = 1'b1;
        held_addr = out_addr;
        held_data = out_data;
        stall++;
      end
    end else begin
      held  = 1'b0;
      stall = 0;
    end

    if (dense_en) begin
      dense_run++;
    end else if (done) begin
      check("dense_len_before_done", dense_run, DENSE_CYC);
      done_cnt++;
      dense_run = 0;
    end else begin
      dense_run = 0;
    end
  end

  // Fill memories, build expected results per window, then pulse start.
  task automatic start_job(input bit pass);
    exp_t e;
    logic [9*SIZE-1:0] w, k;
    pass_mode = pass;
    for (int a = 0; a < NPIX; a++) pix_mem[a] = pass ? SIZE'(a) : SIZE'($urandom);
    for (int j = 0; j < 9; j++)    wt_mem[j]  = SIZE'($urandom);
    for (int j = 0; j < 9; j++)    k[j*SIZE +: SIZE] = wt_mem[j];
    for (int r = 0; r < IMG_H-2; r++) begin
      for (int c = 0; c < IMG_W-2; c++) begin
        for (int j = 0; j < 9; j++)
          w[j*SIZE +: SIZE] = pix_mem[(r + j/3)*IMG_W + c + j%3];
        e.addr = ADDR_W'(r*(IMG_W-2) + c);
        e.data = dp_fn(w, k, pass);
        exp_q.push_back(e);
      end
    end
    done_cnt  = 0;
    n_job_out = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(name, seen, 1);
  endtask

  task automatic finish_job(input string name);
    repeat (4) @(negedge clk);
    check({name, "_outputs_left"}, exp_q.size(), 0);
    check({name, "_output_count"}, n_job_out, N_OUT);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_idle_after"}, busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"},      busy, 0);
    check({name, "_done"},      done, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_data"},  out_data, 0);
    check({name, "_out_addr"},  out_addr, 0);
    check({name, "_pix_rd"},    pix_rd, 0);
    check({name, "_pix_addr"},  pix_addr, 0);
    check({name, "_wt_rd"},     wt_rd, 0);
    check({name, "_wt_addr"},   wt_addr, 0);
    check({name, "_conv_en"},   conv_en, 0);
    check({name, "_dense_en"},  dense_en, 0);
    check({name, "_win_zero"},  (win_flat != '0), 0);
    check({name, "_kern_zero"}, (kern_flat != '0), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int fires;
    int pix_seq [9];
    for (int j = 0; j < 9; j++) pix_seq[j] = (j/3)*IMG_W + j%3;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy_after_release", busy, 0);

    // Job 1: address check with pass-through stub plus cycle-exact timing.
    start_job(1'b1);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      check($sformatf("c%0d_wt_rd", k), wt_rd, (k >= 1 && k <= 9));
      if (k >= 1 && k <= 9) check($sformatf("c%0d_wt_addr", k), wt_addr, k-1);
      check($sformatf("c%0d_pix_rd", k), pix_rd, (k >= 11 && k <= 19));
      if (k >= 11 && k <= 19) check($sformatf("c%0d_pix_addr", k), pix_addr, pix_seq[k-11]);
      check($sformatf("c%0d_conv_en", k), conv_en, (k == 21));
      check($sformatf("c%0d_out_valid", k), out_valid, (k == 24));
      check($sformatf("c%0d_busy", k), busy, 1);
    end
    wait_done(2000, "job1_done");
    finish_job("job1");

    // Job 2: random data, random back-pressure, 5-cycle stall on output 3,
    // start pulsed during FETCH and DENSE.
    rand_ready = 1'b1; bp_arm = 1'b1; bp_check = 1'b1;
    start_job(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (pix_rd) seen = 1'b1;
    end
    check("job2_fetch_seen", seen, 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (dense_en) seen = 1'b1;
    end
    check("job2_dense_seen", seen, 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100, "job2_done");
    finish_job("job2");
    repeat (6) @(negedge clk);
    check("job2_no_restart", busy, 0);
    bp_check = 1'b0;

    // Job 3: abort in WAIT of output 10.
    start_job(1'b0);
    fires = 0;
    for (int i = 0; i < 5000 && fires < 11; i++) begin
      @(negedge clk);
      if (conv_en) fires++;
    end
    check("job3_fire_11_seen", fires, 11);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_conv_en", conv_en, 0);
    check("abort_dense_en", dense_en, 0);
    check("abort_outputs_before", n_job_out, 10);
    exp_q.delete();
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_stays_idle", busy, 0);

    // Job 4: fresh job after abort runs from output 0.
    start_job(1'b0);
    wait_done(5000, "job4_done");
    finish_job("job4");

    // Job 5: asynchronous reset while a result is stalled in WRITE.
    rand_ready = 1'b0; ready_level = 1'b0;
    start_job(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("job5_write_seen", seen, 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    exp_q.delete();
    ready_level = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", busy, 0);
    check("post_reset_no_done", done_cnt, 0);
    check("post_reset_out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
